// File: rtl/bram_arbiter_pkg.sv
// Shared configuration for the on-chip bram and the types used by its arbiter.
package configure;

    // Number of 32-bit words in the on-chip bram.
    localparam int bram_depth = 1024;

    // One access request as presented to the bram.
    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bram_req_type;

    // Which requester owns the access in flight (also used for round-robin history).
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_type;

endpackage

// File: rtl/bram_req_slot.sv
// One-entry pending slot: holds a request that lost arbitration until it is issued.
module bram_req_slot
    import configure::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  bram_req_type req_in,
    output logic         pend,
    output bram_req_type req_out
);

    logic         pend_reg;
    bram_req_type req_reg;

    // Capture a deferred request on load, drop the flag once the request is issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_reg <= 1'b0;
            req_reg  <= '0;
        end else if (load) begin
            pend_reg <= 1'b1;
            req_reg  <= req_in;
        end else if (clear) begin
            pend_reg <= 1'b0;
        end
    end

    assign pend    = pend_reg;
    assign req_out = req_reg;

endmodule

// File: rtl/bram_arbiter.sv
// Shares the single-ported bram between instruction fetch (I) and load/store (D).
// One access in flight at a time; the bram answers exactly one cycle after issue,
// and a new access may be issued on that answer cycle for full throughput.
module bram_arbiter
    import configure::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Port index 0 is instruction fetch, index 1 is load/store.
    logic [1:0]   live_valid;
    logic [1:0]   pend;
    logic [1:0]   req_any;
    logic [1:0]   grant;
    logic [1:0]   slot_load;
    bram_req_type live_req [2];
    bram_req_type pend_req [2];
    bram_req_type eff_req  [2];
    bram_req_type issue_req;

    logic [0:0] state_reg, state_next;
    owner_type  owner_reg, owner_next;
    owner_type  last_reg, last_next;
    owner_type  winner;
    logic       issue_slot;
    logic       resp_valid;

    assign live_valid = {dmem_valid, imem_valid};
    assign live_req[0] = '{instr: 1'b1, addr: imem_addr, wdata: 32'h0, wstrb: 4'h0};
    assign live_req[1] = '{instr: 1'b0, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_any[gi]   = live_valid[gi] | pend[gi];
            assign eff_req[gi]   = pend[gi] ? pend_req[gi] : live_req[gi];
            // A live request that is not granted this cycle must not be lost.
            assign slot_load[gi] = live_valid[gi] & ~grant[gi];

            bram_req_slot u_slot (
                .clock   (clock),
                .reset   (reset),
                .load    (slot_load[gi]),
                .clear   (grant[gi]),
                .req_in  (live_req[gi]),
                .pend    (pend[gi]),
                .req_out (pend_req[gi])
            );
        end
    endgenerate

    // The bram is free when idle or when the current access answers this cycle.
    assign issue_slot = ~reset & ((state_reg == ST_IDLE) | bram_ready);
    assign resp_valid = ~reset & (state_reg == ST_WAIT) & bram_ready;

    // Grant: a lone requester wins; on a tie the port that did not win the last tie wins.
    always_comb begin
        grant = 2'b00;
        if (issue_slot) begin
            if (req_any == 2'b11) begin
                if (last_reg == OWN_I) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end else begin
                grant = req_any;
            end
        end
    end

    assign winner = grant[1] ? OWN_D : OWN_I;

    // Request mux toward the bram; all fields are zero when nothing is issued.
    always_comb begin
        issue_req = '0;
        if (grant[1]) begin
            issue_req = eff_req[1];
        end else if (grant[0]) begin
            issue_req = eff_req[0];
        end
    end

    assign bram_valid = |grant;
    assign bram_instr = issue_req.instr;
    assign bram_addr  = issue_req.addr;
    assign bram_wdata = issue_req.wdata;
    assign bram_wstrb = issue_req.wstrb;

    // Route the answer only to the port that owns the access in flight.
    assign imem_ready = resp_valid & (owner_reg == OWN_I);
    assign dmem_ready = resp_valid & (owner_reg == OWN_D);
    assign imem_rdata = imem_ready ? bram_rdata : 32'h0;
    assign dmem_rdata = dmem_ready ? bram_rdata : 32'h0;

    // Next-state: move to WAIT on any issue, fall back to IDLE when an issue slot goes unused.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        if (issue_slot) begin
            if (|grant) begin
                state_next = ST_WAIT;
                owner_next = winner;
            end else begin
                state_next = ST_IDLE;
            end
            if (req_any == 2'b11) begin
                last_next = winner;
            end
        end
    end

    // State, owner and tie history registers; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_I;
            last_reg  <= OWN_I;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomised and directed bench for bram_arbiter against a cycle-level reference model.
module tb_bram_arbiter;
    import configure::*;

    localparam int AW = $clog2(bram_depth);

    logic        clock;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        bram_valid;
    logic        bram_instr;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic [31:0] bram_rdata;
    logic        bram_ready;

    int checks = 0;
    int errors = 0;

    bram_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .bram_valid (bram_valid),
        .bram_instr (bram_instr),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_rdata (bram_rdata),
        .bram_ready (bram_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural bram: read-first, answers exactly one cycle after a request.
    // Unwritten words read back as their own word index.
    logic [31:0] bmem [bram_depth];
    bit          bwritten [bram_depth];
    logic [31:0] bcur, bnew;
    initial begin
        bram_ready = 1'b0;
        bram_rdata = 32'h0;
    end
    always @(posedge clock) begin
        bram_ready <= bram_valid;
        bram_rdata <= 32'h0;
        if (bram_valid) begin
            bcur = bwritten[bram_addr[2 +: AW]] ? bmem[bram_addr[2 +: AW]] : 32'(bram_addr[2 +: AW]);
            bnew = bcur;
            for (int b = 0; b < 4; b++)
                if (bram_wstrb[b]) bnew[8*b +: 8] = bram_wdata[8*b +: 8];
            bram_rdata <= bcur;
            bmem[bram_addr[2 +: AW]] <= bnew;
            bwritten[bram_addr[2 +: AW]] <= 1'b1;
        end
    end

    // Reference model state: one access per cycle since the bram always answers next cycle.
    logic [31:0]  ref_mem [bram_depth];
    bit           m_infl;
    bit           m_owner_d;
    bit           m_last_d;
    logic [31:0]  m_data;
    logic [31:0]  m_addr;
    bit           pend_i, pend_d;
    bram_req_type preq_i, preq_d;

    // Observations from the most recent cycle, for directed spot checks.
    logic        obs_bvalid, obs_binstr, obs_iready, obs_dready;
    logic [31:0] obs_irdata, obs_drdata;
    int          cnt_i, cnt_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_infl    = 1'b0;
        m_owner_d = 1'b0;
        m_last_d  = 1'b0;
        pend_i    = 1'b0;
        pend_d    = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        repeat (n) begin
            @(negedge clock);
            chk("rst_bram_valid", bram_valid, 0);
            chk("rst_bram_addr", bram_addr, 0);
            chk("rst_imem_ready", imem_ready, 0);
            chk("rst_dmem_ready", dmem_ready, 0);
            chk("rst_dmem_rdata", dmem_rdata, 0);
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive inputs, predict, compare at negedge, then advance the model.
    task automatic cycle(input bit iv, input logic [31:0] ia, input bit dv,
                         input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
        bram_req_type ri, rd, w;
        bit           want_i, want_d, any, win_d, e_iready, e_dready;
        int           idx;
        imem_valid = iv;
        imem_addr  = ia;
        dmem_valid = dv;
        dmem_addr  = da;
        dmem_wdata = dw;
        dmem_wstrb = ds;
        ri = pend_i ? preq_i : '{instr: 1'b1, addr: ia, wdata: 32'h0, wstrb: 4'h0};
        rd = pend_d ? preq_d : '{instr: 1'b0, addr: da, wdata: dw, wstrb: ds};
        want_i = pend_i || iv;
        want_d = pend_d || dv;
        any    = want_i || want_d;
        win_d  = (want_i && want_d) ? !m_last_d : want_d;
        w      = any ? (win_d ? rd : ri) : '0;
        e_iready = m_infl && !m_owner_d;
        e_dready = m_infl && m_owner_d;

        @(negedge clock);
        chk("bram_valid", bram_valid, any);
        chk("bram_instr", bram_instr, w.instr);
        chk("bram_addr", bram_addr, w.addr);
        chk("bram_wdata", bram_wdata, w.wdata);
        chk("bram_wstrb", bram_wstrb, w.wstrb);
        chk("imem_ready", imem_ready, e_iready);
        chk("imem_rdata", imem_rdata, e_iready ? m_data : 32'h0);
        chk("dmem_ready", dmem_ready, e_dready);
        chk("dmem_rdata", dmem_rdata, e_dready ? m_data : 32'h0);
        obs_bvalid = bram_valid;
        obs_binstr = bram_instr;
        obs_iready = imem_ready;
        obs_dready = dmem_ready;
        obs_irdata = imem_rdata;
        obs_drdata = dmem_rdata;
        if (imem_ready === 1'b1) cnt_i++;
        if (dmem_ready === 1'b1) cnt_d++;
        if (m_infl)
            $display("txn %s addr=%h rdata=%h", m_owner_d ? "D" : "I", m_addr, m_owner_d ? dmem_rdata : imem_rdata);

        @(posedge clock);
        #1;
        if (want_i && want_d) m_last_d = win_d;
        m_infl    = any;
        m_owner_d = win_d;
        if (any) begin
            idx    = int'(w.addr[2 +: AW]);
            m_addr = w.addr;
            m_data = ref_mem[idx];
            for (int b = 0; b < 4; b++)
                if (w.wstrb[b]) ref_mem[idx][8*b +: 8] = w.wdata[8*b +: 8];
            if (win_d) begin
                pend_d = 1'b0;
                if (iv) begin pend_i = 1'b1; preq_i = ri; end
            end else begin
                pend_i = 1'b0;
                if (dv) begin pend_d = 1'b1; preq_d = rd; end
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        int sent_i, sent_d;
        bit iv, dv;
        for (int i = 0; i < bram_depth; i++) ref_mem[i] = 32'(i);
        imem_addr  = 32'h0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        dmem_wstrb = 4'h0;
        cnt_i = 0;
        cnt_d = 0;
        do_reset(2);
        idle();

        // Lone fetch from 0x10.
        cycle(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("lone_fetch_issue", obs_binstr, 1);
        idle();
        chk("lone_fetch_ready", obs_iready, 1);
        chk("lone_fetch_data", obs_irdata, 32'h4);
        chk("lone_fetch_dready", obs_dready, 0);

        // Half-word store then load of the same word.
        cycle(1'b0, 32'h0, 1'b1, 32'h20, 32'hDEADBEEF, 4'h3);
        cycle(1'b0, 32'h0, 1'b1, 32'h20, 32'h0, 4'h0);
        idle();
        chk("store_load_merge", obs_drdata, 32'h0000BEEF);

        // First tie after reset: D first, I one cycle later.
        do_reset(1);
        cycle(1'b1, 32'h30, 1'b1, 32'h34, 32'h0, 4'h0);
        chk("tie_d_first", obs_binstr, 0);
        idle();
        chk("tie_d_ready", obs_dready, 1);
        chk("tie_i_issue", obs_binstr, 1);
        idle();
        chk("tie_i_ready", obs_iready, 1);

        // Continuous contention, ten requests per port.
        cnt_i = 0; cnt_d = 0; sent_i = 0; sent_d = 0;
        for (int c = 0; c < 40 && (sent_i < 10 || sent_d < 10); c++) begin
            iv = !pend_i && sent_i < 10;
            dv = !pend_d && sent_d < 10;
            if (iv) sent_i++;
            if (dv) sent_d++;
            cycle(iv, 32'(4 * $urandom_range(0, bram_depth - 1)), dv,
                  32'(4 * $urandom_range(0, bram_depth - 1)), $urandom, 4'($urandom_range(0, 15)));
        end
        idle();
        idle();
        chk("contention_i_readies", 32'(cnt_i), 32'd10);
        chk("contention_d_readies", 32'(cnt_d), 32'd10);

        // Fetch arriving while a load is in flight goes out on the load's answer cycle.
        cycle(1'b0, 32'h0, 1'b1, 32'h50, 32'h0, 4'h0);
        cycle(1'b1, 32'h54, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("dwait_fetch_issue", obs_bvalid, 1);
        chk("dwait_d_ready", obs_dready, 1);
        idle();
        chk("dwait_i_ready", obs_iready, 1);
        chk("dwait_i_data", obs_irdata, 32'h15);

        // Reset while an access is in flight and the other port is pending.
        cycle(1'b1, 32'h60, 1'b1, 32'h64, 32'h0, 4'h0);
        do_reset(1);
        cnt_i = 0; cnt_d = 0;
        idle();
        idle();
        chk("rst_wait_no_ready", 32'(cnt_i + cnt_d), 32'd0);
        chk("rst_wait_no_issue", obs_bvalid, 0);
        cycle(1'b1, 32'h70, 1'b0, 32'h0, 32'h0, 4'h0);
        idle();
        chk("post_rst_fetch", obs_iready, 1);
        chk("post_rst_data", obs_irdata, 32'h1C);

        // Random traffic under the one-outstanding-per-port protocol.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset(1);
            iv = !pend_i && ($urandom_range(0, 2) != 0);
            dv = !pend_d && ($urandom_range(0, 2) != 0);
            cycle(iv, 32'(4 * $urandom_range(0, bram_depth - 1)), dv,
                  32'(4 * $urandom_range(0, bram_depth - 1)), $urandom,
                  ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
